// File: rtl/cam_rgb565_capture.sv
// Frames the 8-bit camera byte stream into RGB565 pixels, cropped to H_ACT x V_ACT per frame.
// state   | meaning
// IDLE    | stopped; waits for wStCnn
// WAIT_VS | armed; waits for the VSYNC falling edge
// CAPTURE | assembling pixels until the VSYNC rising edge
module cam_rgb565_capture #(
  parameter int H_ACT = 480,
  parameter int V_ACT = 272
) (
  input  logic        iClk,
  input  logic        wRsn,
  input  logic        wEnClk,
  input  logic        wStCnn,
  input  logic        iCamVsync,
  input  logic        iCamHref,
  input  logic [7:0]  iCamData,
  output logic        wFgRgb565Valid,
  output logic [15:0] wRgb565,
  output logic        wFrameDone,
  output logic        wCapBusy
);

  localparam int COL_W  = $clog2(H_ACT + 1);
  localparam int LINE_W = $clog2(V_ACT + 1);
  localparam logic [COL_W-1:0]  COL_MAX  = COL_W'(H_ACT);
  localparam logic [LINE_W-1:0] LINE_MAX = LINE_W'(V_ACT);
  localparam logic [COL_W-1:0]  COL_ONE  = COL_W'(1);
  localparam logic [LINE_W-1:0] LINE_ONE = LINE_W'(1);

  typedef enum logic [1:0] {IDLE, WAIT_VS, CAPTURE} tState;

  tState             state, stateNxt;
  logic              vsPrev, hrefPrev;
  logic              phase, phaseNxt;
  logic [7:0]        hiByte, hiNxt;
  logic [COL_W-1:0]  col, colNxt;
  logic [LINE_W-1:0] line, lineNxt;
  logic              validNxt, doneNxt;
  logic [15:0]       rgbNxt;

  logic vsRise, vsFall, hrefFall;
  assign vsRise   = iCamVsync & ~vsPrev;
  assign vsFall   = ~iCamVsync & vsPrev;
  assign hrefFall = ~iCamHref & hrefPrev;
  assign wCapBusy = (state != IDLE);

  always_comb begin
    stateNxt = state;
    phaseNxt = phase;
    hiNxt    = hiByte;
    colNxt   = col;
    lineNxt  = line;
    validNxt = 1'b0;
    rgbNxt   = wRgb565;
    doneNxt  = 1'b0;
    if (wStCnn) begin
      stateNxt = WAIT_VS;
      phaseNxt = 1'b0;
      colNxt   = '0;
      lineNxt  = '0;
    end else begin
      case (state)
        IDLE: begin
        end
        WAIT_VS: begin
          if (vsFall) begin
            stateNxt = CAPTURE;
            phaseNxt = 1'b0;
            colNxt   = '0;
            lineNxt  = '0;
          end
        end
        CAPTURE: begin
          if (vsRise) begin
            // frame end; a half-assembled pixel is simply abandoned
            stateNxt = WAIT_VS;
            doneNxt  = 1'b1;
            phaseNxt = 1'b0;
          end else if (iCamHref) begin
            phaseNxt = ~phase;
            if (!phase) begin
              hiNxt = iCamData;
            end else begin
              if ((col < COL_MAX) && (line < LINE_MAX)) begin
                validNxt = 1'b1;
                rgbNxt   = {hiByte, iCamData};
              end
              if (col < COL_MAX) colNxt = col + COL_ONE;
            end
          end else begin
            phaseNxt = 1'b0;
            if (hrefFall) begin
              colNxt = '0;
              if (line < LINE_MAX) lineNxt = line + LINE_ONE;
            end
          end
        end
        default: stateNxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge iClk or negedge wRsn) begin
    if (!wRsn) begin
      state          <= IDLE;
      vsPrev         <= 1'b0;
      hrefPrev       <= 1'b0;
      phase          <= 1'b0;
      hiByte         <= '0;
      col            <= '0;
      line           <= '0;
      wFgRgb565Valid <= 1'b0;
      wRgb565        <= '0;
      wFrameDone     <= 1'b0;
    end else if (wEnClk) begin
      state          <= stateNxt;
      vsPrev         <= iCamVsync;
      hrefPrev       <= iCamHref;
      phase          <= phaseNxt;
      hiByte         <= hiNxt;
      col            <= colNxt;
      line           <= lineNxt;
      wFgRgb565Valid <= validNxt;
      wRgb565        <= rgbNxt;
      wFrameDone     <= doneNxt;
    end
  end

endmodule

// File: tb/tb_cam_rgb565_capture.sv
// Directed bench for cam_rgb565_capture with a small 3x2 crop window.
module tb_cam_rgb565_capture;

  logic        iClk = 1'b0;
  logic        wRsn;
  logic        wEnClk;
  logic        wStCnn;
  logic        iCamVsync;
  logic        iCamHref;
  logic [7:0]  iCamData;
  logic        wFgRgb565Valid;
  logic [15:0] wRgb565;
  logic        wFrameDone;
  logic        wCapBusy;

  cam_rgb565_capture #(.H_ACT(3), .V_ACT(2)) dut (
    .iClk(iClk), .wRsn(wRsn), .wEnClk(wEnClk), .wStCnn(wStCnn),
    .iCamVsync(iCamVsync), .iCamHref(iCamHref), .iCamData(iCamData),
    .wFgRgb565Valid(wFgRgb565Valid), .wRgb565(wRgb565),
    .wFrameDone(wFrameDone), .wCapBusy(wCapBusy)
  );

  always #5 iClk = ~iClk;

  int nChecks = 0;
  int nErr = 0;
  int doneCnt = 0;
  logic [15:0] gotPix[$];
  logic [15:0] expPix[$];
  logic [7:0]  lineBuf[$];

  typedef struct {
    logic        st, vs, href;
    logic [7:0]  d;
    logic        eValid;
    logic [15:0] eRgb;
    logic        eDone, eBusy;
  } tVec;
  tVec vecs[15];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // pixels/frame-done are counted as an enabled downstream consumer would see them
  task automatic step(input logic en, input logic st, input logic vs, input logic href,
                      input logic [7:0] d);
    @(negedge iClk);
    if (en && wFgRgb565Valid) gotPix.push_back(wRgb565);
    if (en && wFrameDone) doneCnt++;
    wEnClk = en; wStCnn = st; iCamVsync = vs; iCamHref = href; iCamData = d;
    @(posedge iClk);
    #1;
  endtask

  task automatic startFrame();
    step(1, 1, 0, 0, 8'h00);
    step(1, 0, 1, 0, 8'h00);
    step(1, 0, 1, 0, 8'h00);
    step(1, 0, 0, 0, 8'h00);
  endtask

  // gap inserts a disabled cycle with VSYNC high / HREF low that must not be seen
  task automatic sendLine(input logic gap);
    foreach (lineBuf[i]) begin
      step(1, 0, 0, 1, lineBuf[i]);
      if (gap) step(0, 0, 1, 0, 8'hFF);
    end
    step(1, 0, 0, 0, 8'h00);
    if (gap) step(0, 0, 1, 1, 8'hFF);
    step(1, 0, 0, 0, 8'h00);
    lineBuf.delete();
  endtask

  task automatic endFrame(input logic gap);
    step(1, 0, 1, 0, 8'h00);
    if (gap) step(0, 0, 0, 0, 8'h00);
    step(1, 0, 1, 0, 8'h00);
    if (gap) step(0, 0, 0, 0, 8'h00);
    step(1, 0, 1, 0, 8'h00);
  endtask

  task automatic comparePix(input string name, input int expDone);
    chk({name, "_count"}, gotPix.size(), expPix.size());
    for (int i = 0; i < expPix.size() && i < gotPix.size(); i++)
      chk($sformatf("%s_pix%0d", name, i), gotPix[i], expPix[i]);
    chk({name, "_done"}, doneCnt, expDone);
    gotPix.delete();
    expPix.delete();
    doneCnt = 0;
  endtask

  initial begin
    wRsn = 1'b0; wEnClk = 1'b1; wStCnn = 1'b0;
    iCamVsync = 1'b0; iCamHref = 1'b0; iCamData = 8'h00;

    vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b1};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b1};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b1};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 8'h12, 1'b0, 16'h0000, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 8'h34, 1'b1, 16'h1234, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 8'h56, 1'b0, 16'h1234, 1'b0, 1'b1};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 8'h78, 1'b1, 16'h5678, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 16'h5678, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 8'h9A, 1'b0, 16'h5678, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 8'hBC, 1'b1, 16'h9ABC, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 8'hDE, 1'b0, 16'h9ABC, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 8'hF0, 1'b1, 16'hDEF0, 1'b0, 1'b1};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 16'hDEF0, 1'b0, 1'b1};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 16'hDEF0, 1'b1, 1'b1};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 16'hDEF0, 1'b0, 1'b1};

    repeat (3) @(posedge iClk);
    #1;
    chk("rst_valid", wFgRgb565Valid, 0);
    chk("rst_rgb", wRgb565, 0);
    chk("rst_done", wFrameDone, 0);
    chk("rst_busy", wCapBusy, 0);
    @(negedge iClk);
    wRsn = 1'b1;
    step(1, 0, 0, 0, 8'h00);
    chk("idle_busy", wCapBusy, 0);

    // basic two-line frame, cycle-exact
    for (int i = 0; i < 15; i++) begin
      step(1, vecs[i].st, vecs[i].vs, vecs[i].href, vecs[i].d);
      chk($sformatf("vec%0d_valid", i), wFgRgb565Valid, vecs[i].eValid);
      chk($sformatf("vec%0d_rgb", i), wRgb565, vecs[i].eRgb);
      chk($sformatf("vec%0d_done", i), wFrameDone, vecs[i].eDone);
      chk($sformatf("vec%0d_busy", i), wCapBusy, vecs[i].eBusy);
    end
    gotPix.delete();
    doneCnt = 0;

    // oversized frame: 5 pixels x 4 lines cropped to 3 x 2
    startFrame();
    for (int l = 0; l < 4; l++) begin
      for (int c = 0; c < 5; c++) begin
        lineBuf.push_back(8'(8'h10 * (l + 1) + c));
        lineBuf.push_back(8'(8'hC0 + c));
        if (l < 2 && c < 3) expPix.push_back({8'(8'h10 * (l + 1) + c), 8'(8'hC0 + c)});
      end
      sendLine(1'b0);
    end
    endFrame(1'b0);
    comparePix("crop", 1);

    // odd trailing byte is dropped and next line restarts at phase 0
    startFrame();
    lineBuf = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    sendLine(1'b0);
    lineBuf = '{8'h66, 8'h77, 8'h88, 8'h99};
    sendLine(1'b0);
    endFrame(1'b0);
    expPix = '{16'h1122, 16'h3344, 16'h6677, 16'h8899};
    comparePix("odd", 1);

    // enable active 1-of-2 cycles with misleading inputs in the gaps
    startFrame();
    lineBuf = '{8'h12, 8'h34, 8'h56, 8'h78};
    sendLine(1'b1);
    lineBuf = '{8'h9A, 8'hBC, 8'hDE, 8'hF0};
    sendLine(1'b1);
    endFrame(1'b1);
    expPix = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};
    comparePix("gap", 1);

    // restart mid-line: nothing until next VSYNC fall, counters back at zero
    startFrame();
    step(1, 0, 0, 1, 8'h01);
    step(1, 0, 0, 1, 8'h02);
    step(1, 0, 0, 1, 8'h03);
    step(1, 1, 0, 1, 8'h04);
    lineBuf = '{8'h05, 8'h06, 8'h07, 8'h08};
    sendLine(1'b0);
    lineBuf = '{8'h09, 8'h0A};
    sendLine(1'b0);
    chk("restart_busy", wCapBusy, 1);
    step(1, 0, 1, 0, 8'h00);
    step(1, 0, 0, 0, 8'h00);
    lineBuf = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    sendLine(1'b0);
    lineBuf = '{8'hEE, 8'hFF, 8'h11, 8'h22};
    sendLine(1'b0);
    lineBuf = '{8'h33, 8'h44};
    sendLine(1'b0);
    endFrame(1'b0);
    expPix = '{16'h0102, 16'hAABB, 16'hCCDD, 16'hEEFF, 16'h1122};
    comparePix("restart", 1);

    // async reset right after a high byte
    startFrame();
    step(1, 0, 0, 1, 8'h12);
    step(1, 0, 0, 1, 8'h34);
    step(1, 0, 0, 1, 8'h56);
    chk("pre_rst_rgb", wRgb565, 16'h1234);
    #2;
    wRsn = 1'b0;
    #1;
    chk("arst_valid", wFgRgb565Valid, 0);
    chk("arst_rgb", wRgb565, 0);
    chk("arst_done", wFrameDone, 0);
    chk("arst_busy", wCapBusy, 0);
    @(negedge iClk);
    wRsn = 1'b1;
    gotPix.delete();
    doneCnt = 0;
    step(1, 0, 1, 0, 8'h00);
    step(1, 0, 0, 0, 8'h00);
    lineBuf = '{8'h78, 8'h9A, 8'hBC, 8'hDE};
    sendLine(1'b0);
    endFrame(1'b0);
    chk("post_rst_busy", wCapBusy, 0);
    comparePix("post_rst", 0);
    startFrame();
    lineBuf = '{8'h5A, 8'hA5};
    sendLine(1'b0);
    endFrame(1'b0);
    expPix = '{16'h5AA5};
    comparePix("rearm", 1);

    $display("Result: errors=%0d of %0d checks", nErr, nChecks);
    $finish;
  end

endmodule

// File: doc/cam_rgb565_capture.md
# cam_rgb565_capture

Camera-side capture stage that turns the 8-bit parallel sensor stream (VSYNC/HREF/DATA, two bytes per pixel) into 16-bit RGB565 pixels. It feeds the output-buffer write controller directly. That controller consumes `wFgRgb565Valid`/`wRgb565` and advances its 17-bit write address once per valid pixel, wrapping at 130560 = 480x272. This block frames and crops the sensor output to exactly `H_ACT` x `V_ACT` pixels per frame, so the downstream address count stays aligned frame to frame.

## Interface
- `H_ACT`, default 480: active pixels kept per line; columns beyond are dropped.
- `V_ACT`, default 272: active lines kept per frame; lines beyond are dropped.
- `iClk`  in  1  system clock.
- `wRsn`  in  1  asynchronous, active-low reset.
- `wEnClk`  in  1  camera pixel-clock enable. All state advances and all camera inputs are sampled only on cycles with `wEnClk`=1.
- `wStCnn`  in  1  start/restart capture; sampled on `wEnClk` cycles.
- `iCamVsync`  in  1  sensor VSYNC, active high; the falling edge marks frame start.
- `iCamHref`  in  1  sensor HREF, high during valid line bytes.
- `iCamData`  in  8  sensor data byte.
- `wFgRgb565Valid`  out  1  pixel valid.
- `wRgb565`  out  16  assembled pixel: first byte → [15:8], second byte → [7:0].
- `wFrameDone`  out  1  end-of-frame flag.
- `wCapBusy`  out  1  high in WAIT_VS and CAPTURE.

## Operation
- Registered copies of `iCamVsync`/`iCamHref` (previous tick values) give edge detection. An edge is only evaluated on `wEnClk` ticks.
- FSM states:
  - IDLE (reset state).
  - WAIT_VS: wait for VSYNC falling edge.
  - CAPTURE.
- Transitions:
  - IDLE → WAIT_VS on `wStCnn`.
  - WAIT_VS → CAPTURE on VSYNC 1→0.
  - CAPTURE → WAIT_VS on VSYNC 0→1; `wFrameDone` pulses. Capture is continuous, frame after frame, until reset or `wStCnn`.
- `wStCnn` in any state: go to WAIT_VS and clear the byte phase, column and line counters. `wStCnn` has priority over all other events on the same tick.
- In CAPTURE with HREF=1, each tick toggles the byte phase:
  - Phase 0: latch `iCamData` as the high byte.
  - Phase 1: form the pixel from the high byte and `iCamData`.
  - The pixel is emitted only if column < `H_ACT` and line < `V_ACT`.
  - Column increments on every phase-1 byte, whether or not the pixel is emitted; it saturates at `H_ACT`.
- HREF=0 resets byte phase to 0; an odd trailing byte is discarded.
- On HREF 1→0 in CAPTURE: column ← 0 and line ← line+1, saturating at `V_ACT`.
- On entering CAPTURE, column and line are cleared to 0.
- Column width is ⌈log2(`H_ACT`+1)⌉ bits and line width is ⌈log2(`V_ACT`+1)⌉ bits. No wrap in either counter.
- A full-size frame yields exactly `H_ACT`*`V_ACT` valid pixels. A short frame (VSYNC early) yields fewer pixels; no padding is added.
- VSYNC rising edge mid-line: treated as frame end, with any partial pixel dropped.

## Timing
- Reset values: FSM=IDLE, `wFgRgb565Valid`=0, `wRgb565`=0, `wFrameDone`=0, `wCapBusy`=0. All internal counters and registers are also 0.
- All outputs are registered and update only on `wEnClk` ticks. They hold between ticks.
- Pixel latency: for a second byte sampled on tick N, `wRgb565` and `wFgRgb565Valid`=1 appear after the clock edge of tick N. Valid clears on tick N+1 unless another pixel completes then.
- Consequence: downstream logic gated by `wEnClk` sees each pixel on exactly one enabled cycle.
- `wRgb565` holds the last pixel when valid is low.
- `wFrameDone`: asserted on the tick the VSYNC rising edge is sampled in CAPTURE, and cleared on the next tick.
- Asynchronous reset mid-frame: outputs go to reset values immediately and the FSM returns to IDLE. A new `wStCnn` is required to restart capture.
- With `wEnClk` held 0: no state change, and no edge is detected across the gap.

## Test plan
- Reset, then `wStCnn`. Send VSYNC pulse, then 2 lines of 4 bytes `12 34 56 78` (`H_ACT`=2, `V_ACT`=2) → 4 valid pulses, with `wRgb565`=0x1234, 0x5678 per line. After the next VSYNC rise, `wFrameDone` pulses once.
- Default params, full 640x480 sensor frame → exactly 130560 valid pulses; the column crop drops pixels 480..639 and lines 272..479 are silent.
- Line with odd byte count (5 bytes) → 2 pixels emitted; the 5th byte is dropped and the next line starts at phase 0.
- `wEnClk` toggling 1-of-2 cycles → each valid is seen high on exactly one `wEnClk`=1 cycle. Pixel values are unchanged.
- `wStCnn` asserted mid-line in CAPTURE → no further valid until the next VSYNC falling edge, and the next frame starts at column 0 and line 0.
- Assert `wRsn` low mid-pixel (after the high byte) → all outputs 0 at once. After release, no capture occurs until `wStCnn`.
